// File: rtl/micro_seq_cond.sv
// Microprogram sequencer: N/Z/V/C flag register, 4-bit condition select, CAR with jump/call/return/map.
// Optional FLAG_BYPASS_EN: conditions evaluate on incoming ALU flags during a flag write.
module micro_seq_cond #(
    parameter int AW          = 7,
    parameter int STACK_DEPTH = 4,
    parameter int SPW         = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flag_we,
    input  logic            i_n,
    input  logic            i_z,
    input  logic            i_v,
    input  logic            i_c,
    input  logic [3:0]      i_ms,
    input  logic [1:0]      i_br,
    input  logic [AW-1:0]   i_ad,
    input  logic            i_map_en,
    input  logic [AW-1:0]   i_map_addr,
    input  logic            i_stall,
    output logic [AW-1:0]   o_car,
    output logic [3:0]      o_flags,
    output logic            o_cond,
    output logic [SPW-1:0]  o_sp,
    output logic            o_stack_err
);

    localparam logic [SPW-1:0] DEPTH_C = SPW'(STACK_DEPTH);

    logic [AW-1:0]  car_q, car_d;
    logic [3:0]     flags_q, flags_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [AW-1:0]  car_inc;
    logic [AW-1:0]  stack_top;
    logic [3:0]     eval_flags;
    logic           cond;
    logic           push;
    logic           n_f, z_f, v_f, c_f, lt_f;

`ifdef FLAG_BYPASS_EN
    assign eval_flags = i_flag_we ? {i_n, i_z, i_v, i_c} : flags_q;
`else
    assign eval_flags = flags_q;
`endif

    assign {n_f, z_f, v_f, c_f} = eval_flags;
    assign lt_f = n_f ^ v_f;

    always_comb begin
        cond = 1'b0;
        case (i_ms)
            4'h0: cond = 1'b0;
            4'h1: cond = 1'b1;
            4'h2: cond = c_f;
            4'h3: cond = v_f;
            4'h4: cond = z_f;
            4'h5: cond = n_f;
            4'h6: cond = ~c_f;
            4'h7: cond = ~z_f;
            4'h8: cond = ~n_f;
            4'h9: cond = ~v_f;
            4'hA: cond = lt_f;
            4'hB: cond = ~lt_f;
            4'hC: cond = z_f | lt_f;
            4'hD: cond = ~z_f & ~lt_f;
            4'hE: cond = c_f & ~z_f;
            4'hF: cond = ~c_f | z_f;
            default: cond = 1'b0;
        endcase
    end

    assign car_inc = car_q + AW'(1);

    // Entry sp-1 is the most recent return address.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        car_d   = car_q;
        sp_d    = sp_q;
        flags_d = flags_q;
        err_d   = err_q;
        push    = 1'b0;
        if (!i_stall) begin
            if (i_flag_we) begin
                flags_d = {i_n, i_z, i_v, i_c};
            end
            if (i_map_en) begin
                car_d = i_map_addr;
            end else begin
                case (i_br)
                    2'b00: car_d = car_inc;
                    2'b01: car_d = cond ? i_ad : car_inc;
                    2'b10: begin
                        car_d = car_inc;
                        if (cond) begin
                            if (sp_q < DEPTH_C) begin
                                push  = 1'b1;
                                sp_d  = sp_q + SPW'(1);
                                car_d = i_ad;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        car_d = car_inc;
                        if (cond) begin
                            if (sp_q != '0) begin
                                sp_d  = sp_q - SPW'(1);
                                car_d = stack_top;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            car_q   <= '0;
            flags_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            car_q   <= car_d;
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SPW'(i)) begin
                    stack_q[i] <= car_inc;
                end
            end
        end
    end

    assign o_car       = car_q;
    assign o_flags     = flags_q;
    assign o_cond      = cond;
    assign o_sp        = sp_q;
    assign o_stack_err = err_q;

endmodule

// File: tb/tb_micro_seq_cond.sv
// Self-checking bench for micro_seq_cond: directed vectors, an abstract queue-based model, per-cycle compare.
module tb_micro_seq_cond;

    localparam int AW = 7;
    localparam int SD = 4;
    localparam int SPW = 3;

    logic          clk, rst;
    logic          flag_we, n, z, v, c, map_en, stall;
    logic [3:0]    ms;
    logic [1:0]    br;
    logic [AW-1:0] ad, map_addr;
    logic [AW-1:0] car;
    logic [3:0]    flags;
    logic          cond;
    logic [SPW-1:0] sp;
    logic          serr;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Abstract model state
    int m_car;
    int m_flags;
    int m_err;
    int m_stk[$];

    micro_seq_cond #(.AW(AW), .STACK_DEPTH(SD), .SPW(SPW)) dut (
        .i_clk(clk), .i_rst(rst), .i_flag_we(flag_we),
        .i_n(n), .i_z(z), .i_v(v), .i_c(c),
        .i_ms(ms), .i_br(br), .i_ad(ad),
        .i_map_en(map_en), .i_map_addr(map_addr), .i_stall(stall),
        .o_car(car), .o_flags(flags), .o_cond(cond), .o_sp(sp), .o_stack_err(serr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int model_cond(input int sel, input int f);
        bit fn, fz, fv, fc;
        fn = f[3]; fz = f[2]; fv = f[1]; fc = f[0];
        case (sel)
            0:  return 0;
            1:  return 1;
            2:  return fc;
            3:  return fv;
            4:  return fz;
            5:  return fn;
            6:  return !fc;
            7:  return !fz;
            8:  return !fn;
            9:  return !fv;
            10: return fn != fv;
            11: return fn == fv;
            12: return fz || (fn != fv);
            13: return !fz && (fn == fv);
            14: return fc && !fz;
            default: return !fc || fz;
        endcase
    endfunction

    function automatic int eff_flags();
`ifdef FLAG_BYPASS_EN
        if (flag_we) return {28'd0, n, z, v, c};
`endif
        return m_flags;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_car = 0; m_flags = 0; m_err = 0;
            m_stk.delete();
        end else if (!stall) begin
            int taken;
            taken = model_cond(int'(ms), eff_flags());
            if (map_en) m_car = int'(map_addr);
            else if (br == 2'b00) m_car = (m_car + 1) % (1 << AW);
            else if (br == 2'b01) m_car = taken ? int'(ad) : (m_car + 1) % (1 << AW);
            else if (br == 2'b10) begin
                if (taken && m_stk.size() < SD) begin
                    m_stk.push_back((m_car + 1) % (1 << AW));
                    m_car = int'(ad);
                end else begin
                    if (taken) m_err = 1;
                    m_car = (m_car + 1) % (1 << AW);
                end
            end else begin
                if (taken && m_stk.size() > 0) m_car = m_stk.pop_back();
                else begin
                    if (taken) m_err = 1;
                    m_car = (m_car + 1) % (1 << AW);
                end
            end
            if (flag_we) m_flags = {28'd0, n, z, v, c};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("car", int'(car), m_car);
            chk("flags", int'(flags), m_flags);
            chk("sp", int'(sp), m_stk.size());
            chk("stack_err", int'(serr), m_err);
            chk("cond", int'(cond), model_cond(int'(ms), eff_flags()));
        end
    end

    task automatic cycle(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_in(input bit fwe, input bit [3:0] f, input bit [3:0] sel,
                          input bit [1:0] b, input int a, input bit men, input int maddr,
                          input bit stl);
        flag_we = fwe; {n, z, v, c} = f; ms = sel; br = b; ad = AW'(a);
        map_en = men; map_addr = AW'(maddr); stall = stl;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("rst_car", int'(car), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_sp", int'(sp), 0);
        chk("rst_err", int'(serr), 0);
        #1 rst = 0;
    endtask

    initial begin
        int pre_car;
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk_en = 1;

        // Build up nonzero state, then reset asynchronously between edges
        set_in(1, 4'hF, 4'h1, 2'b10, 8, 0, 0, 0);
        cycle(1);
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        cycle(3);
        pulse_reset();

        // Sequential flow and wrap
        cycle(127);
        chk("seq_127", int'(car), 127);
        cycle(1);
        chk("seq_wrap", int'(car), 0);
        cycle(2);
        chk("seq_130", int'(car), 2);

        // Signed/unsigned conditions with N=1 Z=0 V=0 C=1
        set_in(1, 4'b1001, 4'h0, 2'b00, 0, 0, 0, 0);
        cycle(1);
        flag_we = 0;
        chk("flags_load", int'(flags), 4'b1001);
        ms = 4'hA; #1 chk("cond_A", int'(cond), 1);
        ms = 4'hC; #1 chk("cond_C", int'(cond), 1);
        ms = 4'hE; #1 chk("cond_E", int'(cond), 1);
        ms = 4'hB; #1 chk("cond_B", int'(cond), 0);
        ms = 4'hD; #1 chk("cond_D", int'(cond), 0);
        ms = 4'hF; #1 chk("cond_F", int'(cond), 0);
        set_in(0, 4'h0, 4'hA, 2'b01, 'h40, 0, 0, 0);
        cycle(1);
        chk("jump_lt", int'(car), 'h40);

        // Call / return
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 1, 'h10, 0);
        cycle(1);
        set_in(0, 4'h0, 4'h1, 2'b10, 'h30, 0, 0, 0);
        cycle(1);
        chk("call_car", int'(car), 'h30);
        chk("call_sp", int'(sp), 1);
        set_in(0, 4'h0, 4'h1, 2'b11, 0, 0, 0, 0);
        cycle(1);
        chk("ret_car", int'(car), 'h11);
        chk("ret_sp", int'(sp), 0);

        // Not-taken call leaves the stack alone
        set_in(0, 4'h0, 4'h0, 2'b10, 'h30, 0, 0, 0);
        cycle(1);
        chk("call_nt_car", int'(car), 'h12);
        chk("call_nt_sp", int'(sp), 0);

        // Overflow: four pushes succeed, fifth advances CAR and sets error
        for (int k = 0; k < 4; k++) begin
            set_in(0, 4'h0, 4'h1, 2'b10, 'h20 + k, 0, 0, 0);
            cycle(1);
        end
        chk("push4_sp", int'(sp), 4);
        set_in(0, 4'h0, 4'h1, 2'b10, 'h50, 0, 0, 0);
        cycle(1);
        chk("ovf_car", int'(car), 'h24);
        chk("ovf_sp", int'(sp), 4);
        chk("ovf_err", int'(serr), 1);
        set_in(0, 4'h0, 4'h1, 2'b11, 0, 0, 0, 0);
        cycle(4);
        chk("unwind_car", int'(car), 'h13);
        chk("unwind_sp", int'(sp), 0);

        // Underflow after reset
        pulse_reset();
        cycle(1);
        chk("unf_car", int'(car), 1);
        chk("unf_err", int'(serr), 1);
        chk("unf_sp", int'(sp), 0);
        pulse_reset();

        // Stall beats map and flag write
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 1, 'h20, 0);
        cycle(1);
        set_in(1, 4'hF, 4'h1, 2'b01, 'h33, 1, 'h66, 1);
        cycle(2);
        chk("stall_car", int'(car), 'h20);
        chk("stall_flags", int'(flags), 0);

        // Map beats call
        set_in(0, 4'h0, 4'h1, 2'b10, 'h33, 1, 'h55, 0);
        cycle(1);
        chk("map_car", int'(car), 'h55);
        chk("map_sp", int'(sp), 0);

        // Flag write in the same cycle as a jump on Z
        set_in(1, 4'b0100, 4'h4, 2'b01, 'h7A, 0, 0, 0);
        cycle(1);
`ifdef FLAG_BYPASS_EN
        chk("same_cycle_jump", int'(car), 'h7A);
`else
        chk("same_cycle_jump", int'(car), 'h56);
`endif
        chk("same_cycle_flags", int'(flags), 4'b0100);

        // Mixed pseudo-random traffic checked by the model every cycle
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom), 2'($urandom),
                   int'($urandom_range(0, 127)), $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, 127)), $urandom_range(0, 7) == 0);
            cycle(1);
        end
        pre_car = int'(car);
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        cycle(1);
        chk("final_inc", int'(car), (pre_car + 1) % 128);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_seq_cond.md
Name: micro_seq_cond

Overview:
Microprogram sequencer for the RISC control unit, successor to the 3-bit flag condition select.
- Holds the architectural N/Z/V/C flag register.
- Evaluates a 4-bit condition select with signed and unsigned compare codes.
- Drives the control address register (CAR) with increment, conditional jump, conditional call/return through a parametrised return stack, and opcode map.
- Sits between the ALU flag outputs and the control memory address input.

Parameters:
AW, 7, microaddress width (CAR, branch and map addresses)
STACK_DEPTH, 4, return-stack entries (>=1)
SPW, 3, stack-pointer width; must satisfy 2^SPW > STACK_DEPTH

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_flag_we  in  1  load i_n/i_z/i_v/i_c into flag register
i_n  in  1  ALU negative
i_z  in  1  ALU zero
i_v  in  1  ALU overflow
i_c  in  1  ALU carry (1 = no borrow on subtract)
i_ms  in  4  condition select
i_br  in  2  branch type: 00 next, 01 jump-if, 10 call-if, 11 return-if
i_ad  in  AW  branch/call target
i_map_en  in  1  load CAR from i_map_addr (instruction decode)
i_map_addr  in  AW  opcode-mapped address
i_stall  in  1  hold CAR, stack and flags
o_car  out  AW  current microaddress
o_flags  out  4  registered {N,Z,V,C}
o_cond  out  1  selected condition (combinational)
o_sp  out  SPW  stack occupancy, 0..STACK_DEPTH
o_stack_err  out  1  sticky overflow/underflow

Behaviour:
- Reset (async, i_rst=1): o_car=0, o_flags=0, o_sp=0, o_stack_err=0, stack contents=0. Reset mid-call discards the stack.
- Flags: on a clock edge with i_flag_we=1 and i_stall=0, o_flags<={i_n,i_z,i_v,i_c}. Otherwise hold.
- o_cond is combinational from i_ms and o_flags, with N,Z,V,C taken from o_flags:
  - 0:0, 1:1, 2:C, 3:V, 4:Z, 5:N, 6:~C, 7:~Z. Codes 0-7 are identical to the legacy 3-bit select.
  - 8:~N, 9:~V, A:N^V (signed lt), B:~(N^V) (signed ge).
  - C:Z|(N^V) (signed le), D:~Z&~(N^V) (signed gt).
  - E:C&~Z (unsigned hi), F:~C|Z (unsigned ls).
- Next CAR, applied on the clock edge. Priority: stall > map > branch type.
  - i_stall=1: CAR, stack, sp and flags hold.
  - i_map_en=1: CAR<=i_map_addr. i_br is ignored.
  - 00: CAR<=CAR+1, wrapping modulo 2^AW (all-ones -> 0).
  - 01: CAR<=o_cond ? i_ad : CAR+1.
  - 10, o_cond=1, sp<STACK_DEPTH: stack[sp]<=CAR+1, sp<=sp+1, CAR<=i_ad.
  - 10, o_cond=1, sp==STACK_DEPTH (overflow): no push, CAR<=CAR+1, o_stack_err<=1.
  - 11, o_cond=1, sp>0: CAR<=stack[sp-1], sp<=sp-1.
  - 11, o_cond=1, sp==0 (underflow): CAR<=CAR+1, o_stack_err<=1.
  - 10/11 with o_cond=0: CAR<=CAR+1, stack untouched.
- o_stack_err is cleared only by reset.
- Flag write in the same cycle as a conditional branch: the branch uses the old (registered) flags; new flags are visible next cycle.
- Latency: o_car changes 1 cycle after the decision inputs are sampled.

Optional Feature:
FLAG_BYPASS_EN
- Defined: when i_flag_we=1, o_cond evaluates on the incoming i_n/i_z/i_v/i_c instead of o_flags, so the same-cycle branch sees the new flags. The flag register update is unchanged.
- Undefined: o_cond always uses o_flags.

Test Plan:
- Reset with i_rst pulsed asynchronously between edges -> o_car=0, o_flags=0, o_sp=0, o_stack_err=0 immediately, without waiting for a clock edge.
- Sequential flow: i_br=00 for 130 cycles from reset, AW=7 -> o_car counts 0..127, wraps to 0, reaches 2.
- Signed/unsigned conditions: load flags N=1,V=0,Z=0,C=1 -> o_cond=1 for i_ms=A,C,E; o_cond=0 for B,D,F. i_br=01, i_ad=0x40 with i_ms=A -> o_car=0x40 next cycle.
- Call/return: at CAR=0x10, call to 0x30 (i_ms=1) -> o_car=0x30, o_sp=1. Return (i_ms=1) -> o_car=0x11, o_sp=0.
- Stack overflow/underflow: 5 calls with STACK_DEPTH=4 -> 5th call advances CAR by 1, o_sp stays 4, o_stack_err=1. After reset, a return at sp=0 -> CAR+1, o_stack_err=1.
- Priority/stall, plus flag/branch same-cycle:
  - i_stall=1 with i_map_en=1 and i_flag_we=1 -> nothing changes.
  - i_map_en=1 with i_br=10 -> o_car=i_map_addr, o_sp unchanged.
  - Flag write Z=1 in the same cycle as jump on i_ms=4 with old Z=0 -> no jump without FLAG_BYPASS_EN; jump with it defined.
